score_accumulator: RTL and testbench

//  Downstream stage of the per-hit scoring logic. It consumes one judged hit per
//  hit_valid pulse: base_score, bonus_score and the new combo. It keeps the song's

---
 rtl/score_accumulator.sv | 152 +++++++++++++++
 tb/tb_score_accumulator.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/score_accumulator.sv
// Per-song score accumulator: running totals, song progress FSM and optional health bar.
// Define SCORE_HP_EN to build the health bar; otherwise hp is fixed at HP_MAX and failed at 0.
//
//  state  | meaning
//  S_IDLE | out of reset, waiting for the first start
//  S_PLAY | song running, hits are accepted
//  S_DONE | song finished (all notes seen or health exhausted), waiting for start
module score_accumulator #(
  parameter int W           = 32,
  parameter int HP_MAX      = 100,
  parameter int HP_MISS_DEC = 10,
  parameter int HP_HIT_INC  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] total_note,
  input  logic [1:0]   mod,
  input  logic         hit_valid,
  input  logic [W-1:0] base_score,
  input  logic [W-1:0] bonus_score,
  input  logic [W-1:0] combo,
  output logic [W-1:0] last_combo,
  output logic [W-1:0] now_cnt,
  output logic [W-1:0] last_base_score,
  output logic [W-1:0] total_score,
  output logic [W-1:0] max_combo,
  output logic [W-1:0] miss_cnt,
  output logic         playing,
  output logic         done,
  output logic [7:0]   hp,
  output logic         failed
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  localparam logic [W-1:0] MAX_VAL = '1;
  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [7:0]   HP_FULL = 8'(HP_MAX);

  state_t       state, state_next;
  logic [W-1:0] total_note_q;
  logic         accept;
  logic         is_miss;
  logic         fail_now;
  logic [W-1:0] cnt_inc;
  logic [W-1:0] hit_sum;

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W] ? MAX_VAL : s[W-1:0];
  endfunction

  assign accept  = hit_valid && !start && (state == S_PLAY);
  assign is_miss = (base_score == '0);
  assign cnt_inc = sat_add(now_cnt, ONE);
  assign hit_sum = sat_add(base_score, bonus_score);

`ifdef SCORE_HP_EN
  localparam logic [7:0] HP_DEC = 8'(HP_MISS_DEC);
  localparam logic [7:0] HP_INC = 8'(HP_HIT_INC);

  logic [1:0] mod_q;
  logic [7:0] hp_q;
  logic [7:0] hp_next;
  logic [8:0] hp_sum;
  logic       failed_q;

  always_comb begin
    hp_sum  = {1'b0, hp_q} + {1'b0, HP_INC};
    hp_next = hp_q;
    if (is_miss) begin
      hp_next = (hp_q > HP_DEC) ? (hp_q - HP_DEC) : 8'd0;
    end else begin
      hp_next = (hp_sum >= {1'b0, HP_FULL}) ? HP_FULL : hp_sum[7:0];
    end
  end

  // No Fail mode lets health sit at zero without ending the song.
  assign fail_now = accept && (hp_next == 8'd0) && (mod_q != 2'b01);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mod_q    <= 2'b00;
      hp_q     <= HP_FULL;
      failed_q <= 1'b0;
    end else if (start) begin
      mod_q    <= mod;
      hp_q     <= HP_FULL;
      failed_q <= 1'b0;
    end else if (accept) begin
      hp_q <= hp_next;
      if (fail_now) failed_q <= 1'b1;
    end
  end

  assign hp     = hp_q;
  assign failed = failed_q;
`else
  logic unused_hp_cfg;
  assign unused_hp_cfg = ^{mod, HP_MISS_DEC, HP_HIT_INC};
  assign fail_now      = 1'b0;
  assign hp            = HP_FULL;
  assign failed        = 1'b0;
`endif

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = (total_note == '0) ? S_DONE : S_PLAY;
    end else if (accept && ((cnt_inc == total_note_q) || fail_now)) begin
      state_next = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total_note_q    <= '0;
      last_combo      <= '0;
      now_cnt         <= '0;
      last_base_score <= '0;
      total_score     <= '0;
      max_combo       <= '0;
      miss_cnt        <= '0;
    end else if (start) begin
      total_note_q    <= total_note;
      last_combo      <= '0;
      now_cnt         <= '0;
      last_base_score <= '0;
      total_score     <= '0;
      max_combo       <= '0;
      miss_cnt        <= '0;
    end else if (accept) begin
      now_cnt         <= cnt_inc;
      last_base_score <= sat_add(last_base_score, base_score);
      total_score     <= sat_add(total_score, hit_sum);
      last_combo      <= combo;
      if (combo > max_combo) max_combo <= combo;
      if (is_miss) miss_cnt <= sat_add(miss_cnt, ONE);
    end
  end

  assign playing = (state == S_PLAY);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_score_accumulator.sv
// Directed bench for score_accumulator: vector table for scoring, hand sequences for
// reset, idle hits and the health bar (expectations follow SCORE_HP_EN).
module tb_score_accumulator;
  localparam int W = 32;
  localparam logic [W-1:0] MAXV = '1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] total_note = '0;
  logic [1:0]   mod = 2'b00;
  logic         hit_valid = 1'b0;
  logic [W-1:0] base_score = '0;
  logic [W-1:0] bonus_score = '0;
  logic [W-1:0] combo = '0;
  logic [W-1:0] last_combo, now_cnt, last_base_score, total_score, max_combo, miss_cnt;
  logic         playing, done, failed;
  logic [7:0]   hp;

  int n_checks = 0;
  int n_pass = 0;

  score_accumulator #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .total_note(total_note), .mod(mod),
    .hit_valid(hit_valid), .base_score(base_score), .bonus_score(bonus_score), .combo(combo),
    .last_combo(last_combo), .now_cnt(now_cnt), .last_base_score(last_base_score),
    .total_score(total_score), .max_combo(max_combo), .miss_cnt(miss_cnt),
    .playing(playing), .done(done), .hp(hp), .failed(failed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         st;
    logic [W-1:0] tn;
    logic         hv;
    logic [W-1:0] b, bo, c;
    logic [W-1:0] e_now, e_lb, e_ts, e_mc, e_lc, e_miss;
    logic         e_play, e_done;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, " now_cnt"}, now_cnt, v.e_now);
    chk({tag, " last_base"}, last_base_score, v.e_lb);
    chk({tag, " total"}, total_score, v.e_ts);
    chk({tag, " max_combo"}, max_combo, v.e_mc);
    chk({tag, " last_combo"}, last_combo, v.e_lc);
    chk({tag, " miss_cnt"}, miss_cnt, v.e_miss);
    chk({tag, " playing"}, W'(playing), W'(v.e_play));
    chk({tag, " done"}, W'(done), W'(v.e_done));
  endtask

  task automatic step(input logic st, input logic [W-1:0] tn, input logic [1:0] md,
                      input logic hv, input logic [W-1:0] b, input logic [W-1:0] bo,
                      input logic [W-1:0] c);
    start = st; total_note = tn; mod = md;
    hit_valid = hv; base_score = b; bonus_score = bo; combo = c;
    @(posedge clk);
    #1;
    start = 1'b0; hit_valid = 1'b0;
  endtask

  vec_t vecs[12];
  vec_t zero_idle;
  logic hp_en;
  logic [7:0] exp_hp;

  initial begin
`ifdef SCORE_HP_EN
    hp_en = 1'b1;
`else
    hp_en = 1'b0;
`endif
    zero_idle = '{0,0,0,0,0,0, 0,0,0,0,0,0, 0,0};
    //            st tn hv b           bo c   now lb    ts    mc lc miss play done
    vecs[0]  = '{1, 3, 0, 0,          0,  0,  0, 0,    0,    0, 0, 0,   1, 0};
    vecs[1]  = '{0, 0, 1, 1562,       156,2,  1, 1562, 1718, 2, 2, 0,   1, 0};
    vecs[2]  = '{0, 0, 1, 1464,       156,3,  2, 3026, 3338, 3, 3, 0,   1, 0};
    vecs[3]  = '{0, 0, 1, 0,          0,  0,  3, 3026, 3338, 3, 0, 1,   0, 1};
    vecs[4]  = '{0, 0, 1, 500,        5,  9,  3, 3026, 3338, 3, 0, 1,   0, 1};
    vecs[5]  = '{1, 4, 0, 0,          0,  0,  0, 0,    0,    0, 0, 0,   1, 0};
    vecs[6]  = '{0, 0, 1, 100,        10, 5,  1, 100,  110,  5, 5, 0,   1, 0};
    vecs[7]  = '{1, 4, 1, 200,        0,  6,  0, 0,    0,    0, 0, 0,   1, 0};
    vecs[8]  = '{0, 0, 1, MAXV,       0,  1,  1, MAXV, MAXV, 1, 1, 0,   1, 0};
    vecs[9]  = '{0, 0, 1, MAXV,       7,  2,  2, MAXV, MAXV, 2, 2, 0,   1, 0};
    vecs[10] = '{0, 0, 1, 3,          0,  1,  3, MAXV, MAXV, 2, 1, 0,   1, 0};
    vecs[11] = '{1, 0, 0, 0,          0,  0,  0, 0,    0,    0, 0, 0,   0, 1};

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", zero_idle);
    chk("reset hp", W'(hp), W'(100));
    chk("reset failed", W'(failed), '0);
    rst_n = 1'b1;

    step(0, 0, 0, 1, 77, 3, 4);
    check_all("idle_hit", zero_idle);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].st, vecs[i].tn, 2'b00, vecs[i].hv, vecs[i].b, vecs[i].bo, vecs[i].c);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset in mid-song must leave nothing behind.
    step(1, 5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 40, 4, 7);
    chk("mid now_cnt", now_cnt, 1);
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0);
    check_all("midrst", zero_idle);
    rst_n = 1'b1;

    // Health: Normal mode, ten misses.
    step(1, 20, 2'b00, 0, 0, 0, 0);
    chk("hp start", W'(hp), W'(100));
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 2'b00, 1, 0, 0, 0);
      exp_hp = hp_en ? 8'(100 - 10 * k) : 8'd100;
      chk($sformatf("hp miss%0d", k), W'(hp), W'(exp_hp));
    end
    chk("hp0 done", W'(done), W'(hp_en));
    chk("hp0 failed", W'(failed), W'(hp_en));
    chk("hp0 playing", W'(playing), W'(!hp_en));
    chk("hp0 miss_cnt", miss_cnt, 10);

    // Health: No Fail mode keeps playing at zero.
    step(1, 20, 2'b01, 0, 0, 0, 0);
    chk("nf failed clr", W'(failed), '0);
    for (int k = 1; k <= 10; k++) step(0, 0, 2'b00, 1, 0, 0, 0);
    chk("nf hp", W'(hp), hp_en ? W'(0) : W'(100));
    chk("nf playing", W'(playing), 1);
    chk("nf failed", W'(failed), '0);
    step(0, 0, 2'b00, 1, 5, 0, 1);
    chk("nf hp inc", W'(hp), hp_en ? W'(2) : W'(100));
    chk("nf now_cnt", now_cnt, 11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
